dbg_rom_bus_adapter: RTL and testbench

- Host-side front end for the debug ROM.
- Converts the core's 32-bit req/gnt/rvalid data-bus protocol into the ROM's request/address interface.
- The ROM's read data is valid one cycle after a request; this block steers the addressed 32-bit half of that data back to the host.
- Buffers responses under host backpressure and flags out-of-range accesses and writes.

---
 rtl/dbg_rom_pkg.sv | 27 ++
 rtl/dbg_rom_resp_fifo.sv | 62 ++++++
 rtl/dbg_rom_bus_adapter.sv | 113 +++++++++++
 tb/tb_dbg_rom_bus_adapter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_rom_pkg.sv
// Shared types and helpers for the debug ROM host adapter.
package dbg_rom_pkg;

  localparam int unsigned RomWords = 19;
  localparam int unsigned RomAddrW = 64;

  // One response as seen by the host: data plus error flag.
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  // What kind of response the request granted last cycle will produce.
  typedef enum logic [1:0] {
    RESP_ROM       = 2'd0,
    RESP_RANGE_ERR = 2'd1,
    RESP_WRITE     = 2'd2
  } resp_kind_e;

  // Byte address is in range when it selects one of the first rom_words
  // 64-bit words inside the 256-byte window at address zero.
  function automatic logic rom_in_range(input logic [RomAddrW-1:0] addr,
                                        input int unsigned rom_words);
    return (addr[RomAddrW-1:8] == '0) && (32'(addr[7:3]) < rom_words);
  endfunction

endpackage

// File: rtl/dbg_rom_resp_fifo.sv
// Fall-through response FIFO: a push into an empty FIFO is visible on the
// output in the same cycle, so a single response costs no extra latency.
module dbg_rom_resp_fifo
  import dbg_rom_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  resp_t                        push_data_i,
  input  logic                         pop_i,
  output logic                         valid_o,
  output resp_t                        data_o,
  output logic [$clog2(Depth+1)-1:0]   count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  resp_t           mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            empty;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + 1'b1;
  endfunction

  // Head of queue, or the incoming entry when nothing is stored yet.
  always_comb begin
    empty   = (count_q == '0);
    valid_o = !empty || push_i;
    data_o  = empty ? push_data_i : mem_q[rd_ptr_q];
    count_o = count_q;
  end

  // Pointers and occupancy; a bypassed entry is written and popped at once,
  // so both pointers advance together and the count stays put.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop_i)  rd_ptr_q <= next_ptr(rd_ptr_q);
      count_q <= count_q + CntW'(push_i) - CntW'(pop_i);
    end
  end

  // Storage array, written on every push.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  // The grant credit scheme must never let a push land on a full FIFO.
  assert property (@(posedge clk_i) disable iff (rst_i)
                   push_i |-> (count_q != CntW'(Depth)));

endmodule

// File: rtl/dbg_rom_bus_adapter.sv
// Host req/gnt/rvalid front end for the debug ROM.
// Optional macro DBG_ROM_ADAPTER_WRITE_ERR_EN: when defined, granted writes
// answer with err=1; otherwise they are silently dropped with err=0.
module dbg_rom_bus_adapter #(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned RomWords  = dbg_rom_pkg::RomWords,
  parameter int unsigned RespDepth = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 host_req_i,
  output logic                 host_gnt_o,
  input  logic [AddrWidth-1:0] host_addr_i,
  input  logic                 host_we_i,
  input  logic [3:0]           host_be_i,
  input  logic [31:0]          host_wdata_i,
  output logic                 host_rvalid_o,
  input  logic                 host_rready_i,
  output logic [31:0]          host_rdata_o,
  output logic                 host_err_o,
  output logic                 rom_req_o,
  output logic [AddrWidth-1:0] rom_addr_o,
  input  logic [63:0]          rom_rdata_i
);

  import dbg_rom_pkg::*;

  localparam int unsigned CntW = $clog2(RespDepth + 1);

`ifdef DBG_ROM_ADAPTER_WRITE_ERR_EN
  localparam logic WriteErr = 1'b1;
`else
  localparam logic WriteErr = 1'b0;
`endif

  logic            in_range;
  logic            credit_ok;
  logic            grant;
  logic [CntW:0]   used_credits;
  logic            inflight_q;
  logic            hi_half_q;
  resp_kind_e      kind_q;
  resp_t           new_resp;
  resp_t           head_resp;
  logic            fifo_valid;
  logic            pop;
  logic [CntW-1:0] fifo_count;
  logic            unused_inputs;

  assign unused_inputs = ^{host_be_i, host_wdata_i};

  // Grant only while the responses already owed fit in the FIFO; a pop in
  // this same cycle is deliberately not counted as a freed slot.
  always_comb begin
    used_credits = {1'b0, fifo_count} + (CntW+1)'(inflight_q);
    credit_ok    = used_credits < (CntW+1)'(RespDepth);
    in_range     = rom_in_range(RomAddrW'(host_addr_i), RomWords);
    grant        = host_req_i && credit_ok && !rst_i;
    host_gnt_o   = grant;
    rom_req_o    = grant && !host_we_i && in_range;
    rom_addr_o   = host_addr_i;
  end

  // Remember what the granted request needs to answer one cycle later.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inflight_q <= 1'b0;
      hi_half_q  <= 1'b0;
      kind_q     <= RESP_ROM;
    end else begin
      inflight_q <= grant;
      if (grant) begin
        hi_half_q <= host_addr_i[2];
        if (host_we_i)     kind_q <= RESP_WRITE;
        else if (in_range) kind_q <= RESP_ROM;
        else               kind_q <= RESP_RANGE_ERR;
      end
    end
  end

  // Build the response from ROM data, which is only valid this cycle.
  always_comb begin
    new_resp = '0;
    unique case (kind_q)
      RESP_ROM:       new_resp.rdata = hi_half_q ? rom_rdata_i[63:32] : rom_rdata_i[31:0];
      RESP_RANGE_ERR: new_resp.err   = 1'b1;
      RESP_WRITE:     new_resp.err   = WriteErr;
      default:        new_resp       = '0;
    endcase
  end

  dbg_rom_resp_fifo #(
    .Depth (RespDepth)
  ) u_resp_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (inflight_q),
    .push_data_i (new_resp),
    .pop_i       (pop),
    .valid_o     (fifo_valid),
    .data_o      (head_resp),
    .count_o     (fifo_count)
  );

  // Host response port; data and error read as zero whenever nothing is valid.
  always_comb begin
    host_rvalid_o = fifo_valid && !rst_i;
    pop           = host_rvalid_o && host_rready_i;
    host_rdata_o  = host_rvalid_o ? head_resp.rdata : 32'h0;
    host_err_o    = host_rvalid_o ? head_resp.err : 1'b0;
  end

endmodule

// File: tb/tb_dbg_rom_bus_adapter.sv
// Self-checking bench for dbg_rom_bus_adapter: directed vector table,
// hand-written backpressure/reset sequences, then randomized traffic
// checked against a queue-based model of the host protocol.
module tb_dbg_rom_bus_adapter;

  localparam int AW = 64;
  localparam int RW = 19;
  localparam int RD = 2;

`ifdef DBG_ROM_ADAPTER_WRITE_ERR_EN
  localparam logic WErr = 1'b1;
`else
  localparam logic WErr = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_i;
  logic          host_req_i;
  logic          host_gnt_o;
  logic [AW-1:0] host_addr_i;
  logic          host_we_i;
  logic [3:0]    host_be_i;
  logic [31:0]   host_wdata_i;
  logic          host_rvalid_o;
  logic          host_rready_i;
  logic [31:0]   host_rdata_o;
  logic          host_err_o;
  logic          rom_req_o;
  logic [AW-1:0] rom_addr_o;
  logic [63:0]   rom_rdata_i;

  logic [63:0] rom_mem [RW];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        req;
    logic        we;
    logic [63:0] addr;
    logic        rready;
    logic        gnt;
    logic        romreq;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  always #5 clk = ~clk;

  dbg_rom_bus_adapter #(
    .AddrWidth (AW),
    .RomWords  (RW),
    .RespDepth (RD)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .host_req_i    (host_req_i),
    .host_gnt_o    (host_gnt_o),
    .host_addr_i   (host_addr_i),
    .host_we_i     (host_we_i),
    .host_be_i     (host_be_i),
    .host_wdata_i  (host_wdata_i),
    .host_rvalid_o (host_rvalid_o),
    .host_rready_i (host_rready_i),
    .host_rdata_o  (host_rdata_o),
    .host_err_o    (host_err_o),
    .rom_req_o     (rom_req_o),
    .rom_addr_o    (rom_addr_o),
    .rom_rdata_i   (rom_rdata_i)
  );

  // ROM model: data for a strobed word appears the following cycle,
  // otherwise the bus carries junk.
  always @(posedge clk) begin
    if (rom_req_o && (int'(rom_addr_o[7:3]) < RW))
      rom_rdata_i <= rom_mem[int'(rom_addr_o[7:3])];
    else
      rom_rdata_i <= {$urandom, $urandom};
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic we, input logic [63:0] addr,
                               input logic rready);
    host_req_i    = req;
    host_we_i     = we;
    host_addr_i   = addr;
    host_rready_i = rready;
    host_be_i     = 4'($urandom);
    host_wdata_i  = $urandom;
    @(negedge clk);
  endtask

  function automatic vec_t mkVec(logic req, logic we, logic [63:0] addr, logic rready,
                                 logic gnt, logic romreq, logic rvalid,
                                 logic [31:0] rdata, logic err);
    vec_t v;
    v.req = req; v.we = we; v.addr = addr; v.rready = rready;
    v.gnt = gnt; v.romreq = romreq; v.rvalid = rvalid; v.rdata = rdata; v.err = err;
    return v;
  endfunction

  task automatic runVec(input vec_t v, input string tag);
    applyStimulus(v.req, v.we, v.addr, v.rready);
    checkOutput({tag, "_gnt"}, 64'(host_gnt_o), 64'(v.gnt));
    checkOutput({tag, "_romreq"}, 64'(rom_req_o), 64'(v.romreq));
    checkOutput({tag, "_rvalid"}, 64'(host_rvalid_o), 64'(v.rvalid));
    if (v.romreq) checkOutput({tag, "_romaddr"}, rom_addr_o, v.addr);
    if (v.rvalid) begin
      checkOutput({tag, "_rdata"}, 64'(host_rdata_o), 64'(v.rdata));
      checkOutput({tag, "_err"}, 64'(host_err_o), 64'(v.err));
    end
    @(posedge clk);
    #1;
  endtask

  // Expected response from the address map: 8-byte words, upper half at +4.
  function automatic exp_t modelResp(input logic [63:0] addr, input logic we);
    exp_t e;
    logic [63:0] word;
    e.rdata = 32'h0;
    e.err   = 1'b0;
    if (we) begin
      e.err = WErr;
    end else if (addr < 64'(RW * 8)) begin
      word    = rom_mem[int'(addr / 8)];
      e.rdata = ((addr % 8) >= 4) ? word[63:32] : word[31:0];
    end else begin
      e.err = 1'b1;
    end
    return e;
  endfunction

  // One cycle of traffic against the model: every granted request owes one
  // response, responses come back in grant order, no more than RD are owed.
  task automatic rndStep(input logic req, input logic we, input logic [63:0] addr,
                         input logic rready);
    logic exp_gnt;
    logic exp_rvalid;
    logic exp_romreq;
    applyStimulus(req, we, addr, rready);
    exp_gnt    = req && (exp_q.size() < RD);
    exp_rvalid = (exp_q.size() > 0);
    exp_romreq = exp_gnt && !we && (addr < 64'(RW * 8));
    checkOutput("rnd_gnt", 64'(host_gnt_o), 64'(exp_gnt));
    checkOutput("rnd_rvalid", 64'(host_rvalid_o), 64'(exp_rvalid));
    checkOutput("rnd_romreq", 64'(rom_req_o), 64'(exp_romreq));
    if (exp_romreq) checkOutput("rnd_romaddr", rom_addr_o, addr);
    if (exp_rvalid) begin
      checkOutput("rnd_rdata", 64'(host_rdata_o), 64'(exp_q[0].rdata));
      checkOutput("rnd_err", 64'(host_err_o), 64'(exp_q[0].err));
      if (rready) void'(exp_q.pop_front());
    end
    if (exp_gnt) exp_q.push_back(modelResp(addr, we));
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_i = 1'b1;
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    logic [63:0] addr;
    for (int i = 0; i < RW; i++) rom_mem[i] = {$urandom, $urandom};
    rom_mem[0]  = 64'h07c0006f_00c0006f;
    rom_mem[1]  = 64'h11112222_33334444;
    rom_mem[2]  = 64'h55556666_77778888;
    rom_mem[18] = 64'hdeadbeef_cafef00d;

    rst_i = 1'b1;
    host_req_i = 1'b0; host_we_i = 1'b0; host_addr_i = '0; host_rready_i = 1'b0;
    host_be_i = '0; host_wdata_i = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;

    // Reset state, observed with the host idle.
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
    checkOutput("rst_gnt", 64'(host_gnt_o), 64'h0);
    checkOutput("rst_rvalid", 64'(host_rvalid_o), 64'h0);
    checkOutput("rst_rdata", 64'(host_rdata_o), 64'h0);
    checkOutput("rst_err", 64'(host_err_o), 64'h0);
    checkOutput("rst_romreq", 64'(rom_req_o), 64'h0);
    @(posedge clk);
    #1;

    // Directed table: word 0 halves, back-to-back, out of range, write,
    // ignored low address bits, last valid word.
    vecs.push_back(mkVec(1, 0, 64'h00, 1, 1, 1, 0, 32'h0, 0));
    vecs.push_back(mkVec(1, 0, 64'h04, 1, 1, 1, 1, 32'h00c0006f, 0));
    vecs.push_back(mkVec(0, 0, 64'h00, 1, 0, 0, 1, 32'h07c0006f, 0));
    vecs.push_back(mkVec(1, 0, 64'h00, 1, 1, 1, 0, 32'h0, 0));
    vecs.push_back(mkVec(1, 0, 64'h08, 1, 1, 1, 1, 32'h00c0006f, 0));
    vecs.push_back(mkVec(1, 0, 64'h10, 1, 1, 1, 1, 32'h33334444, 0));
    vecs.push_back(mkVec(0, 0, 64'h00, 1, 0, 0, 1, 32'h77778888, 0));
    vecs.push_back(mkVec(1, 0, 64'h98, 1, 1, 0, 0, 32'h0, 0));
    vecs.push_back(mkVec(1, 0, 64'h100, 1, 1, 0, 1, 32'h0, 1));
    vecs.push_back(mkVec(1, 1, 64'h00, 1, 1, 0, 1, 32'h0, 1));
    vecs.push_back(mkVec(0, 0, 64'h00, 1, 0, 0, 1, 32'h0, WErr));
    vecs.push_back(mkVec(1, 0, 64'h16, 1, 1, 1, 0, 32'h0, 0));
    vecs.push_back(mkVec(0, 0, 64'h00, 1, 0, 0, 1, 32'h55556666, 0));
    vecs.push_back(mkVec(1, 0, 64'h94, 1, 1, 1, 0, 32'h0, 0));
    vecs.push_back(mkVec(0, 0, 64'h00, 1, 0, 0, 1, 32'hdeadbeef, 0));
    vecs.push_back(mkVec(0, 0, 64'h00, 1, 0, 0, 0, 32'h0, 0));
    foreach (vecs[i]) runVec(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: two grants fill the credits, third waits until a slot
    // is freed by a pop in an earlier cycle; held response stays stable.
    runVec(mkVec(1, 0, 64'h00, 0, 1, 1, 0, 32'h0, 0), "bp0");
    runVec(mkVec(1, 0, 64'h08, 0, 1, 1, 1, 32'h00c0006f, 0), "bp1");
    runVec(mkVec(1, 0, 64'h10, 0, 0, 0, 1, 32'h00c0006f, 0), "bp2");
    runVec(mkVec(1, 0, 64'h10, 0, 0, 0, 1, 32'h00c0006f, 0), "bp3");
    runVec(mkVec(1, 0, 64'h10, 1, 0, 0, 1, 32'h00c0006f, 0), "bp4");
    runVec(mkVec(1, 0, 64'h10, 1, 1, 1, 1, 32'h33334444, 0), "bp5");
    runVec(mkVec(0, 0, 64'h00, 1, 0, 0, 1, 32'h77778888, 0), "bp6");
    runVec(mkVec(0, 0, 64'h00, 1, 0, 0, 0, 32'h0, 0), "bp7");

    // Reset with two responses buffered: they are discarded, then a fresh
    // read completes normally.
    runVec(mkVec(1, 0, 64'h00, 0, 1, 1, 0, 32'h0, 0), "rs0");
    runVec(mkVec(1, 0, 64'h08, 0, 1, 1, 1, 32'h00c0006f, 0), "rs1");
    runVec(mkVec(0, 0, 64'h00, 0, 0, 0, 1, 32'h00c0006f, 0), "rs2");
    rst_i = 1'b1;
    runVec(mkVec(1, 0, 64'h00, 1, 0, 0, 0, 32'h0, 0), "rs3");
    rst_i = 1'b0;
    runVec(mkVec(1, 0, 64'h08, 1, 1, 1, 0, 32'h0, 0), "rs4");
    runVec(mkVec(0, 0, 64'h00, 1, 0, 0, 1, 32'h33334444, 0), "rs5");
    runVec(mkVec(0, 0, 64'h00, 1, 0, 0, 0, 32'h0, 0), "rs6");

    // Randomized traffic against the model.
    doReset();
    for (int n = 0; n < 800; n++) begin
      case ($urandom_range(0, 3))
        0, 1:    addr = 64'($urandom_range(0, RW - 1) * 8 + $urandom_range(0, 7));
        2:       addr = 64'($urandom_range(RW, 31) * 8 + $urandom_range(0, 7));
        default: addr = {$urandom, $urandom} | 64'h100;
      endcase
      rndStep($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, addr,
              $urandom_range(0, 3) != 0);
    end
    for (int n = 0; n < 4; n++) rndStep(1'b0, 1'b0, 64'h0, 1'b1);
    checkOutput("rnd_drained", 64'(exp_q.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
